// File: rtl/palindrome_stream_checker_if.sv
// rtl/palindrome_stream_checker_if.sv - symbol-in / result-out handshake bundle for the palindrome checker
interface palindrome_stream_checker_if #(
  parameter int SYM_W = 8,
  parameter int LEN_W = 5
) ();
  logic             in_valid;
  logic             in_ready;
  logic [SYM_W-1:0] in_data;
  logic             in_last;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic             out_palin;
  logic             out_err;
  logic [LEN_W-1:0] out_len;

  modport slave (
    input  in_valid, in_data, in_last, mode, out_ready,
    output in_ready, out_valid, out_palin, out_err, out_len
  );

  modport master (
    output in_valid, in_data, in_last, mode, out_ready,
    input  in_ready, out_valid, out_palin, out_err, out_len
  );
endinterface

// File: rtl/palindrome_stream_checker.sv
// rtl/palindrome_stream_checker.sv - buffers a framed symbol stream and tests it for symbol- or bit-level palindromicity
module palindrome_stream_checker #(
  parameter int SYM_W = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  palindrome_stream_checker_if.slave bus
);
  localparam int LEN_W = $clog2(DEPTH) + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic signed [LEN_W:0] ONE_S = 1;

  typedef enum logic [1:0] {ST_LOAD, ST_CHECK, ST_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SYM_W-1:0]        r_mem [DEPTH];
  logic [LEN_W-1:0]        r_count;
  logic                    r_err;
  logic                    r_mode_q;
  logic                    r_palin;
  // Signed with one spare bit so hi can step below zero after a length-1 bit-mode compare
  logic signed [LEN_W:0]   r_lo;
  logic signed [LEN_W:0]   r_hi;

  logic                    w_in_ready;
  logic                    w_out_valid;
  logic                    w_in_hs;
  logic                    w_out_hs;
  logic                    w_room;
  logic                    w_pending;
  logic                    w_match;
  logic                    w_step;
  logic                    w_enter_done;
  logic                    w_done_palin;
  logic [LEN_W-1:0]        w_count_after;
  logic [SYM_W-1:0]        w_rd_lo;
  logic [SYM_W-1:0]        w_rd_hi;
  logic [SYM_W-1:0]        w_rev_hi;

  assign w_in_hs       = bus.in_valid && w_in_ready;
  assign w_out_hs      = w_out_valid && bus.out_ready;
  assign w_room        = r_count < DEPTH_L;
  assign w_count_after = w_room ? r_count + 1'b1 : r_count;

  // Combinational reads keep one compare per CHECK cycle with no extra pipeline stage
  assign w_rd_lo   = r_mem[r_lo[AW-1:0]];
  assign w_rd_hi   = r_mem[r_hi[AW-1:0]];
  // Bit mode must also test the middle symbol against itself, hence lo<=hi
  assign w_pending = r_mode_q ? (r_lo <= r_hi) : (r_lo < r_hi);
  assign w_match   = r_mode_q ? (w_rd_lo == w_rev_hi) : (w_rd_lo == w_rd_hi);

  // Mirror the high symbol so a bit-mode compare is a plain equality
  always_comb begin
    w_rev_hi = '0;
    for (int i = 0; i < SYM_W; i++) begin
      w_rev_hi[i] = w_rd_hi[SYM_W-1-i];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; an overflowed frame skips straight to a failing result
  always_comb begin
    w_state_nxt  = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_step       = 1'b0;
    w_enter_done = 1'b0;
    w_done_palin = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) begin
          w_state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (r_err) begin
          w_state_nxt  = ST_DONE;
          w_enter_done = 1'b1;
        end else if (w_pending) begin
          if (w_match) begin
            w_step = 1'b1;
          end else begin
            w_state_nxt  = ST_DONE;
            w_enter_done = 1'b1;
          end
        end else begin
          w_state_nxt  = ST_DONE;
          w_enter_done = 1'b1;
          w_done_palin = 1'b1;
        end
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_nxt = ST_LOAD;
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  // Frame bookkeeping: length, overflow flag, captured mode, compare pointers and verdict
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_err    <= 1'b0;
      r_mode_q <= 1'b0;
      r_palin  <= 1'b0;
      r_lo     <= '0;
      r_hi     <= '0;
    end else begin
      if (w_in_hs) begin
        r_count <= w_count_after;
        if (!w_room) begin
          r_err <= 1'b1;
        end
        if (bus.in_last) begin
          r_mode_q <= bus.mode;
          r_lo     <= '0;
          r_hi     <= $signed({1'b0, w_count_after - 1'b1});
        end
      end
      if (w_step) begin
        r_lo <= r_lo + ONE_S;
        r_hi <= r_hi - ONE_S;
      end
      if (w_enter_done) begin
        r_palin <= w_done_palin;
      end
      if (w_out_hs) begin
        r_count <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  // Symbol buffer; overflow symbols are dropped rather than written
  always_ff @(posedge clk) begin
    if (w_in_hs && w_room) begin
      r_mem[r_count[AW-1:0]] <= bus.in_data;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_palin = r_palin;
  assign bus.out_err   = r_err;
  assign bus.out_len   = r_count;
endmodule
